decode_buffer: RTL and testbench

- Sits directly downstream of the instruction fetch unit and upstream of the execute stage.
- Two-entry instruction queue (the IF/ID stage), accepted on a valid/ready handshake.
- Decodes each accepted instruction into format and immediate, and stores the fetch unit's static branch prediction alongside it.
- Drives same-cycle redirect hints (jmp, branch, target) back to fetch; drops all contents on an execute-stage flush.

---
 rtl/decode_buffer_pkg.sv | 26 ++
 rtl/decode_buffer_imm_gen.sv | 30 +++
 rtl/decode_buffer.sv | 85 ++++++++
 tb/tb_decode_buffer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/decode_buffer_pkg.sv
// decode_buffer_pkg: shared opcodes, formats and queue entry type for the IF/ID buffer
package decode_buffer_pkg;
  localparam int DEPTH = 2;
  localparam int PC_W = 64;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} inst_fmt_e;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_e;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0] inst;
    logic pred;
    inst_fmt_e fmt;
    logic [31:0] imm;
    logic illegal;
  } dec_entry_t;
endpackage

// File: rtl/decode_buffer_imm_gen.sv
// imm_gen_sbm: classifies an RV32I word into format, sign-extended immediate and legality
module imm_gen_sbm
  import decode_buffer_pkg::*;
(
  input  logic [31:0] inst_i,
  output inst_fmt_e   fmt_o,
  output logic [31:0] imm_o,
  output logic        illegal_o
);
  // Opcode decode; anything unrecognised (including inst[1:0]!=11) is illegal with R format
  always_comb begin
    fmt_o = FMT_R;
    illegal_o = 1'b0;
    case (inst_i[6:0])
      OPC_LUI, OPC_AUIPC: fmt_o = FMT_U;
      OPC_JAL: fmt_o = FMT_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_FENCE, OPC_SYSTEM: fmt_o = FMT_I;
      OPC_BRANCH: fmt_o = FMT_B;
      OPC_STORE: fmt_o = FMT_S;
      OPC_OP: fmt_o = FMT_R;
      default: illegal_o = 1'b1;
    endcase
    imm_o = fmt_o == FMT_I ? {{20{inst_i[31]}}, inst_i[31:20]} :
            fmt_o == FMT_S ? {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]} :
            fmt_o == FMT_B ? {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0} :
            fmt_o == FMT_U ? {inst_i[31:12], 12'b0} :
            fmt_o == FMT_J ? {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0} :
            32'b0;
  end
endmodule

// File: rtl/decode_buffer.sv
// decode_buffer: two-entry IF/ID queue with write-time decode and same-cycle fetch redirect hints
module decode_buffer
  import decode_buffer_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic [ADDR_W-1:0] in_pc_i,
  input  logic [31:0]       in_inst_i,
  input  logic              in_pred_taken_i,
  output logic              in_ready_o,
  output logic              jmp_o,
  output logic              branch_o,
  output logic [ADDR_W-1:0] jmp_target_o,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_pc_o,
  output logic [31:0]       out_inst_o,
  output logic              out_pred_taken_o,
  output logic [2:0]        out_fmt_o,
  output logic [31:0]       out_imm_o,
  output logic              out_illegal_o
);
  occ_e state_q, state_d;
  dec_entry_t ent_q [DEPTH];
  dec_entry_t head, wr_ent;
  logic wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic push, pop, fire;
  inst_fmt_e wr_fmt, tgt_fmt;
  logic [31:0] wr_imm, tgt_imm;
  logic wr_ill, tgt_ill;

  imm_gen_sbm u_wr_dec (.inst_i(in_inst_i), .fmt_o(wr_fmt), .imm_o(wr_imm), .illegal_o(wr_ill));
  imm_gen_sbm u_tgt_dec (.inst_i(in_inst_i), .fmt_o(tgt_fmt), .imm_o(tgt_imm), .illegal_o(tgt_ill));

  assign in_ready_o = state_q != FULL;
  assign out_valid_o = state_q != EMPTY;
  assign fire = in_valid_i & in_ready_o & ~flush_i;
  assign push = fire;
  assign pop = out_valid_o & out_ready_i & ~flush_i;
  assign jmp_o = fire & ~tgt_ill & tgt_fmt == FMT_J;
  assign branch_o = fire & ~tgt_ill & tgt_fmt == FMT_B;
  assign jmp_target_o = in_pc_i + ADDR_W'(tgt_imm);
  assign wr_ent = '{pc: PC_W'(in_pc_i), inst: in_inst_i, pred: in_pred_taken_i,
                    fmt: wr_fmt, imm: wr_imm, illegal: wr_ill};
  assign head = ent_q[rd_ptr_q];
  assign out_pc_o = ADDR_W'(head.pc);
  assign out_inst_o = head.inst;
  assign out_pred_taken_o = head.pred;
  assign out_fmt_o = head.fmt;
  assign out_imm_o = head.imm;
  assign out_illegal_o = head.illegal;

  // Occupancy next-state and pointer advance; flush empties and rewinds everything
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: state_d = push ? ONE : EMPTY;
      ONE: state_d = push & ~pop ? FULL : pop & ~push ? EMPTY : ONE;
      FULL: state_d = pop ? ONE : FULL;
      default: state_d = EMPTY;
    endcase
    state_d = flush_i ? EMPTY : state_d;
    wr_ptr_d = flush_i ? 1'b0 : wr_ptr_q ^ push;
    rd_ptr_d = flush_i ? 1'b0 : rd_ptr_q ^ pop;
  end

  // State, pointers and entry storage; reset clears all entries so outputs read zero
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) ent_q[wr_ptr_q] <= wr_ent;
    end
  end
endmodule

// File: tb/tb_decode_buffer.sv
// tb_decode_buffer: table-driven and scoreboard checks of the IF/ID decode buffer
module tb_decode_buffer;
  import decode_buffer_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid_i = 1'b0, in_pred_taken_i = 1'b0, flush_i = 1'b0, out_ready_i = 1'b0;
  logic [31:0] in_pc_i = '0, in_inst_i = '0;
  logic in_ready_o, jmp_o, branch_o, out_valid_o, out_pred_taken_o, out_illegal_o;
  logic [31:0] jmp_target_o, out_pc_o, out_inst_o, out_imm_o;
  logic [2:0] out_fmt_o;
  int checks = 0, errors = 0;

  typedef struct {
    bit v; bit [31:0] pc; bit [31:0] inst; bit pred; bit ordy; bit fl;
    bit ejmp; bit ebr; bit [31:0] etgt; bit [2:0] efmt; bit [31:0] eimm; bit eill;
  } vec_t;
  typedef struct {
    bit [31:0] pc; bit [31:0] inst; bit pred; bit [2:0] fmt; bit [31:0] imm; bit ill;
  } exp_t;
  exp_t sb[$];
  vec_t tbl[14];

  decode_buffer #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_pc_i(in_pc_i), .in_inst_i(in_inst_i),
    .in_pred_taken_i(in_pred_taken_i), .in_ready_o(in_ready_o), .jmp_o(jmp_o), .branch_o(branch_o),
    .jmp_target_o(jmp_target_o), .flush_i(flush_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_pc_o(out_pc_o), .out_inst_o(out_inst_o),
    .out_pred_taken_o(out_pred_taken_o), .out_fmt_o(out_fmt_o), .out_imm_o(out_imm_o),
    .out_illegal_o(out_illegal_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // One cycle: drive at negedge, check just after, update the scoreboard for the coming posedge
  task automatic step(input vec_t v);
    bit push, pop;
    exp_t e;
    @(negedge clk);
    in_valid_i = v.v; in_pc_i = v.pc; in_inst_i = v.inst; in_pred_taken_i = v.pred;
    out_ready_i = v.ordy; flush_i = v.fl;
    #1;
    chk("in_ready", 32'(in_ready_o), 32'(sb.size() < 2));
    chk("out_valid", 32'(out_valid_o), 32'(sb.size() != 0));
    chk("jmp", 32'(jmp_o), 32'(v.ejmp));
    chk("branch", 32'(branch_o), 32'(v.ebr));
    if (v.ejmp || v.ebr) chk("target", jmp_target_o, v.etgt);
    if (sb.size() != 0) begin
      chk("head_pc", out_pc_o, sb[0].pc);
      chk("head_inst", out_inst_o, sb[0].inst);
      chk("head_pred", 32'(out_pred_taken_o), 32'(sb[0].pred));
      chk("head_fmt", 32'(out_fmt_o), 32'(sb[0].fmt));
      chk("head_imm", out_imm_o, sb[0].imm);
      chk("head_illegal", 32'(out_illegal_o), 32'(sb[0].ill));
    end
    push = v.v && sb.size() < 2 && !v.fl;
    pop = sb.size() != 0 && v.ordy && !v.fl;
    e = '{pc: v.pc, inst: v.inst, pred: v.pred, fmt: v.efmt, imm: v.eimm, ill: v.eill};
    if (v.fl) sb.delete();
    else begin
      if (pop) void'(sb.pop_front());
      if (push) sb.push_back(e);
    end
  endtask

  function automatic vec_t mk(bit v, bit [31:0] pc, bit [31:0] inst, bit pred, bit ordy, bit fl,
                              bit ejmp, bit ebr, bit [31:0] etgt, bit [2:0] efmt,
                              bit [31:0] eimm, bit eill);
    mk = '{v: v, pc: pc, inst: inst, pred: pred, ordy: ordy, fl: fl, ejmp: ejmp, ebr: ebr,
           etgt: etgt, efmt: efmt, eimm: eimm, eill: eill};
  endfunction

  function automatic vec_t idle(bit ordy);
    idle = mk(1'b0, 32'h0, 32'h0, 1'b0, ordy, 1'b0, 1'b0, 1'b0, 32'h0, FMT_R, 32'h0, 1'b0);
  endfunction

  initial begin
    tbl[0]  = mk(1'b1, 32'h100, 32'h00500093, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, FMT_I, 32'd5, 1'b0);
    tbl[1]  = mk(1'b1, 32'h104, 32'h00400113, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, FMT_I, 32'd4, 1'b0);
    tbl[2]  = mk(1'b1, 32'h200, 32'hFE000EE3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1FC, FMT_B, 32'hFFFFFFFC, 1'b0);
    tbl[3]  = mk(1'b1, 32'hFFFFFFFC, 32'h0080006F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h4, FMT_J, 32'd8, 1'b0);
    tbl[4]  = mk(1'b1, 32'h1000, 32'hFF9FF06F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFF8, FMT_J, 32'hFFFFFFF8, 1'b0);
    tbl[5]  = mk(1'b1, 32'h10, 32'h123450B7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, FMT_U, 32'h12345000, 1'b0);
    tbl[6]  = mk(1'b1, 32'h14, 32'hFE112C23, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, FMT_S, 32'hFFFFFFF8, 1'b0);
    tbl[7]  = mk(1'b1, 32'h18, 32'h002081B3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, FMT_R, 32'h0, 1'b0);
    tbl[8]  = mk(1'b1, 32'h1C, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, FMT_R, 32'h0, 1'b1);
    tbl[9]  = mk(1'b1, 32'h20, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, FMT_R, 32'h0, 1'b1);
    tbl[10] = mk(1'b1, 32'h24, 32'h00008067, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, FMT_I, 32'h0, 1'b0);
    tbl[11] = mk(1'b1, 32'h28, 32'h00000073, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, FMT_I, 32'h0, 1'b0);
    tbl[12] = mk(1'b1, 32'h2C, 32'hFFFFF517, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, FMT_U, 32'hFFFFF000, 1'b0);
    tbl[13] = mk(1'b1, 32'h30, 32'hFFF00093, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, FMT_I, 32'hFFFFFFFF, 1'b0);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid_o), 32'h0);
    chk("rst_in_ready", 32'(in_ready_o), 32'h1);
    chk("rst_out_pc", out_pc_o, 32'h0);
    chk("rst_out_inst", out_inst_o, 32'h0);
    chk("rst_out_imm", out_imm_o, 32'h0);
    chk("rst_out_fmt", 32'(out_fmt_o), 32'(FMT_R));
    chk("rst_out_pred", 32'(out_pred_taken_o), 32'h0);
    chk("rst_out_illegal", 32'(out_illegal_o), 32'h0);

    // Back-to-back: one push and one pop every cycle through the whole table
    for (int i = 0; i < 14; i++) step(tbl[i]);
    step(idle(1'b1));
    step(idle(1'b1));

    // Fill and stall: two pushes with no consumer, a third (a JAL) is refused with no redirect
    step(mk(1'b1, 32'h100, 32'h00500093, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, FMT_I, 32'd5, 1'b0));
    step(mk(1'b1, 32'h104, 32'h00400113, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, FMT_I, 32'd4, 1'b0));
    step(mk(1'b1, 32'h108, 32'h0080006F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, FMT_J, 32'd8, 1'b0));
    step(idle(1'b0));
    step(idle(1'b1));
    step(idle(1'b1));
    step(idle(1'b1));

    // Flush while FULL with a valid input: queue empties, input dropped
    step(mk(1'b1, 32'h300, 32'h002081B3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, FMT_R, 32'h0, 1'b0));
    step(mk(1'b1, 32'h304, 32'h123450B7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, FMT_U, 32'h12345000, 1'b0));
    step(mk(1'b1, 32'h308, 32'hFE000EE3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, FMT_B, 32'hFFFFFFFC, 1'b0));
    step(idle(1'b0));

    // Flush in ONE with a JAL offered: redirect suppressed, JAL never queued
    step(mk(1'b1, 32'h400, 32'hFE112C23, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, FMT_S, 32'hFFFFFFF8, 1'b0));
    step(mk(1'b1, 32'h404, 32'h0080006F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, FMT_J, 32'd8, 1'b0));
    step(mk(1'b1, 32'h500, 32'hFFF00093, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, FMT_I, 32'hFFFFFFFF, 1'b0));
    step(idle(1'b1));
    step(idle(1'b1));

    // Reset overrides a same-cycle push
    step(mk(1'b1, 32'h600, 32'h00500093, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, FMT_I, 32'd5, 1'b0));
    @(negedge clk);
    rst = 1'b1;
    in_valid_i = 1'b1; in_pc_i = 32'h604; in_inst_i = 32'h00400113; out_ready_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    in_valid_i = 1'b0;
    sb.delete();
    #1;
    chk("rst2_out_valid", 32'(out_valid_o), 32'h0);
    chk("rst2_in_ready", 32'(in_ready_o), 32'h1);
    chk("rst2_out_pc", out_pc_o, 32'h0);
    step(idle(1'b1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
